alu_access_arbiter: RTL

Shares the single ArithmeticLogicUnit between NUM_REQ requesters (e.g. the instruction sequencer, the address unit and a debug port) using a round-robin request/grant handshake. Each granted operation is sequenced through the ALU as capture, issue and collect steps. The arbiter returns the result word and the Z/C/N/O flags to the winner with a one-cycle Done pulse. It sits between the control unit and the ALU, and is the only block that drives the ALU inputs.

---
 rtl/alu_access_arbiter_pkg.sv | 37 +++
 rtl/alu_access_arbiter_if.sv | 40 ++++
 rtl/alu_access_arbiter_picker.sv | 37 +++
 rtl/alu_access_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_access_arbiter_pkg.sv
// Shared types and constants for the ALU access arbiter: FSM states,
// flag-bit layout and the named ALU function-select codes.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam int FLAG_W = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    // Bit 4 selects 32-bit (1) or 16-bit (0) operation; bits 3:0 pick the op.
    localparam int FS_WIDTH_BIT = 4;
    localparam logic [4:0] FS_ADD16 = 5'b00100;
    localparam logic [4:0] FS_AND16 = 5'b00111;
    localparam logic [4:0] FS_ADD32 = 5'b10100;
    localparam logic [4:0] FS_SUB32 = 5'b10110;
    localparam logic [4:0] FS_AND32 = 5'b10111;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic z, input logic c,
                                                     input logic n, input logic o);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_O] = o;
        return f;
    endfunction

endpackage

// File: rtl/alu_access_arbiter_if.sv
// Requester and ALU-side bus of the ALU access arbiter. The slave modport is
// the arbiter's view; master is the view of the requesters plus the ALU.
interface alu_access_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int FUNSEL_W = 5
) ();
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0]          Req;
    logic [NUM_REQ*DATA_W-1:0]   ReqA;
    logic [NUM_REQ*DATA_W-1:0]   ReqB;
    logic [NUM_REQ*FUNSEL_W-1:0] ReqFunSel;
    logic [NUM_REQ-1:0]          ReqWF;
    logic [NUM_REQ-1:0]          Grant;
    logic [NUM_REQ-1:0]          Done;
    logic [DATA_W-1:0]           Result;
    logic [FLAG_W-1:0]           ResultFlags;
    logic                        Busy;

    logic [DATA_W-1:0]           AluA;
    logic [DATA_W-1:0]           AluB;
    logic [FUNSEL_W-1:0]         AluFunSel;
    logic                        AluWF;
    logic [DATA_W-1:0]           AluOut;
    logic [FLAG_W-1:0]           AluFlags;

    modport slave (
        input  Req, ReqA, ReqB, ReqFunSel, ReqWF, AluOut, AluFlags,
        output Grant, Done, Result, ResultFlags, Busy,
        output AluA, AluB, AluFunSel, AluWF
    );

    modport master (
        output Req, ReqA, ReqB, ReqFunSel, ReqWF, AluOut, AluFlags,
        input  Grant, Done, Result, ResultFlags, Busy,
        input  AluA, AluB, AluFunSel, AluWF
    );

endinterface

// File: rtl/alu_access_arbiter_picker.sv
// Combinational round-robin picker: returns the first set request at or above
// ptr_i, wrapping modulo NUM_REQ. Shared with the bus arbiter.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               valid_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    assign valid_o = |req_i;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_access_arbiter.sv
// Round-robin owner of the shared ALU: each granted operation runs
// IDLE -> ISSUE -> COLLECT -> RESP and returns result/flags with a Done pulse.
module alu_access_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int FUNSEL_W = 5
) (
    input logic Clock,
    input logic Reset,
    alu_access_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic [PTR_W-1:0]    owner_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                busy_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [FUNSEL_W-1:0] alu_fs_q;
    logic                alu_wf_q;
    logic [DATA_W-1:0]   result_q;
    logic [FLAG_W-1:0]   flags_q;

    logic [DATA_W-1:0]   req_a  [NUM_REQ];
    logic [DATA_W-1:0]   req_b  [NUM_REQ];
    logic [FUNSEL_W-1:0] req_fs [NUM_REQ];

    logic [PTR_W-1:0]    win_idx;
    logic                win_vld;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i]  = bus.ReqA[i*DATA_W +: DATA_W];
            req_b[i]  = bus.ReqB[i*DATA_W +: DATA_W];
            req_fs[i] = bus.ReqFunSel[i*FUNSEL_W +: FUNSEL_W];
        end
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i    (bus.Req),
        .ptr_i    (rr_ptr_q),
        .winner_o (win_idx),
        .valid_o  (win_vld)
    );

    always_comb begin
        rr_ptr_d = win_idx + PTR_W'(1);
        if (win_idx == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end
    end

    // Grant, Done and AluWF are single-cycle pulses: cleared every edge and
    // set only by the transition that owns them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_fs_q <= '0;
            alu_wf_q <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            grant_q  <= '0;
            done_q   <= '0;
            alu_wf_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        alu_a_q  <= req_a[win_idx];
                        alu_b_q  <= req_b[win_idx];
                        alu_fs_q <= req_fs[win_idx];
                        alu_wf_q <= bus.ReqWF[win_idx];
                        owner_q  <= win_idx;
                        rr_ptr_q <= rr_ptr_d;
                        grant_q  <= NUM_REQ'(1) << win_idx;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= COLLECT;
                end
                COLLECT: begin
                    // Flags are taken even with WF=0; they then echo the ALU's held flags.
                    result_q <= bus.AluOut;
                    flags_q  <= bus.AluFlags;
                    done_q   <= NUM_REQ'(1) << owner_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Grant       = grant_q;
    assign bus.Done        = done_q;
    assign bus.Busy        = busy_q;
    assign bus.Result      = result_q;
    assign bus.ResultFlags = flags_q;
    assign bus.AluA        = alu_a_q;
    assign bus.AluB        = alu_b_q;
    assign bus.AluFunSel   = alu_fs_q;
    assign bus.AluWF       = alu_wf_q;

endmodule
